// File: rtl/inst_encoder.sv
// RV32I instruction encoder with a 2-entry output FIFO.
// Illegal requests are replaced by a NOP carrying an error flag.
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        is_r, is_i, is_s, is_b, is_u, is_j;
    logic        ok_is, ok_b, ok_j, ok_u;
    logic        enc_legal;
    logic [31:0] enc_raw;
    logic [31:0] enc_inst;

    logic [32:0] mem [2];
    logic        wptr, rptr;
    logic [1:0]  count;
    logic        push, pop;

    always_comb begin
        is_r = 1'b0;
        is_i = 1'b0;
        is_s = 1'b0;
        is_b = 1'b0;
        is_u = 1'b0;
        is_j = 1'b0;
        case (in_opcode)
            7'b0000011,
            7'b0010011,
            7'b1100111: is_i = 1'b1;
            7'b0100011: is_s = 1'b1;
            7'b1100011: is_b = 1'b1;
            7'b0010111,
            7'b0110111: is_u = 1'b1;
            7'b1101111: is_j = 1'b1;
            7'b0110011: is_r = 1'b1;
            default:    ;
        endcase
    end

    // Sign-extension checks: upper bits must all match the top kept bit
    assign ok_is = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign ok_b  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign ok_j  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign ok_u  = ~(|in_imm[11:0]);

    always_comb begin
        enc_raw   = NOP;
        enc_legal = 1'b0;
        unique case (1'b1)
            is_r: begin
                enc_raw   = {in_funct7, in_rs2, in_rs1,
                             in_funct3, in_rd, in_opcode};
                enc_legal = 1'b1;
            end
            is_i: begin
                enc_raw   = {in_imm[11:0], in_rs1,
                             in_funct3, in_rd, in_opcode};
                enc_legal = ok_is;
            end
            is_s: begin
                enc_raw   = {in_imm[11:5], in_rs2, in_rs1,
                             in_funct3, in_imm[4:0], in_opcode};
                enc_legal = ok_is;
            end
            is_b: begin
                enc_raw   = {in_imm[12], in_imm[10:5],
                             in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                enc_legal = ok_b;
            end
            is_u: begin
                enc_raw   = {in_imm[31:12], in_rd, in_opcode};
                enc_legal = ok_u;
            end
            is_j: begin
                enc_raw   = {in_imm[20], in_imm[10:1],
                             in_imm[11], in_imm[19:12],
                             in_rd, in_opcode};
                enc_legal = ok_j;
            end
            default: ;
        endcase
    end

    assign enc_inst = enc_legal ? enc_raw : NOP;

    assign in_ready  = rst_n & (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_inst  = out_valid ? mem[rptr][31:0] : 32'h0;
    assign out_err   = out_valid ? mem[rptr][32] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= 33'h0;
            mem[1] <= 33'h0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= {~enc_legal, enc_inst};
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= 16'h0;
            err_count <= 8'h0;
        end else if (push) begin
            enc_count <= enc_count + 16'h1;
            if (!enc_legal && err_count != 8'hFF) begin
                err_count <= err_count + 8'h1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder.
// A queue-based reference model is compared on every falling edge.
module tb_inst_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     name, act, exp);
        end
    endtask

    // Reference encoding: legality as numeric range checks
    function automatic logic [32:0] model_word(
        input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3, input logic [6:0] f7,
        input logic [31:0] imm);
        longint si;
        logic [31:0] w;
        bit ok;
        si = longint'($signed(imm));
        ok = 1'b0;
        w  = 32'h0;
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = {imm[11:0], rs1, f3, rd, op};
            end
            7'b0100011: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            7'b1100011: begin
                ok = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
                w  = {imm[12], imm[10:5], rs2, rs1, f3,
                      imm[4:1], imm[11], op};
            end
            7'b0010111, 7'b0110111: begin
                ok = (imm % 32'd4096) == 0;
                w  = {imm[31:12], rd, op};
            end
            7'b1101111: begin
                ok = (si >= -(64'sd1 << 20)) &&
                     (si < (64'sd1 << 20)) && (si % 2 == 0);
                w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            7'b0110011: begin
                ok = 1'b1;
                w  = {f7, rs2, rs1, f3, rd, op};
            end
            default: ok = 1'b0;
        endcase
        if (!ok) w = 32'h0000_0013;
        return {~ok, w};
    endfunction

    logic [32:0] mq [$];
    int          m_enc;
    int          m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_enc = 0;
            m_err = 0;
        end else begin
            bit acc, pp;
            logic [32:0] wd;
            acc = in_valid && (mq.size() < 2);
            pp  = (mq.size() != 0) && out_ready;
            wd  = model_word(in_opcode, in_rd, in_rs1, in_rs2,
                             in_funct3, in_funct7, in_imm);
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(wd);
                m_enc = (m_enc + 1) % 65536;
                if (wd[32] && m_err < 255) m_err++;
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] hd;
        hd = (mq.size() != 0) ? mq[0] : 33'h0;
        check("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("m_in_ready", 32'(in_ready),
              32'(rst_n && mq.size() < 2));
        check("m_out_inst", out_inst, hd[31:0]);
        check("m_out_err", 32'(out_err), 32'(hd[32]));
        check("m_enc_count", 32'(enc_count), 32'(m_enc));
        check("m_err_count", 32'(err_count), 32'(m_err));
    end

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [31:0] imm);
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = 7'h0;
        in_imm    = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [31:0] imm);
        bit done;
        done = 1'b0;
        set_req(op, rd, rs1, rs2, f3, imm);
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            done = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready never high");
        end
    endtask

    initial begin
        bit          seen_wrap;
        logic [15:0] prev;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_req(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 32'h0);
        #23;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_enc", 32'(enc_count), 32'h0);
        rst_n = 1'b1;
        step();

        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5);
        check("addi", out_inst, 32'h0050_0093);
        check("addi_err", 32'(out_err), 32'h0);
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8);
        check("sw", out_inst, 32'h0020_A423);
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 32'h1234_5000);
        check("lui", out_inst, 32'h1234_52B7);
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFC);
        check("beq", out_inst, 32'hFE00_0EE3);
        check("beq_err", 32'(out_err), 32'h0);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'd3);
        check("jal_bad", out_inst, 32'h0000_0013);
        check("jal_bad_err", 32'(out_err), 32'h1);
        check("err_cnt1", 32'(err_count), 32'h1);
        send(7'b0000000, 5'd1, 5'd0, 5'd0, 3'b000, 32'd0);
        check("op0", out_inst, 32'h0000_0013);
        check("op0_err", 32'(out_err), 32'h1);
        check("err_cnt2", 32'(err_count), 32'h2);
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 32'hDEAD_BEEF);
        send(7'b0010111, 5'd4, 5'd0, 5'd0, 3'b000, 32'h0000_0800);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'h000F_FFFE);
        send(7'b0000011, 5'd2, 5'd3, 5'd0, 3'b010, 32'hFFFF_F800);
        send(7'b0100011, 5'd0, 5'd3, 5'd4, 3'b010, 32'h0000_0800);
        step();

        out_ready = 1'b0;
        set_req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd1);
        in_valid = 1'b1;
        step();
        set_req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2);
        step();
        check("bp_full", 32'(in_ready), 32'h0);
        set_req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd3);
        step();
        check("bp_held", 32'(in_ready), 32'h0);
        check("bp_head", out_inst, 32'h0010_0093);
        out_ready = 1'b1;
        step();
        check("bp_second", out_inst, 32'h0020_0093);
        check("bp_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("bp_third", out_inst, 32'h0030_0093);
        step();
        check("bp_empty", 32'(out_valid), 32'h0);

        set_req(7'b0000000, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0);
        in_valid = 1'b1;
        repeat (320) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("err_sat", 32'(err_count), 32'd255);

        out_ready = 1'b0;
        set_req(7'b0110011, 5'd7, 5'd8, 5'd9, 3'b111, 32'h0);
        in_valid = 1'b1;
        repeat (2) step();
        out_ready = 1'b1;
        seen_wrap = 1'b0;
        prev = enc_count;
        repeat (65540) begin
            step();
            if (prev == 16'hFFFF && enc_count == 16'h0) seen_wrap = 1'b1;
            prev = enc_count;
        end
        check("enc_wrap", 32'(seen_wrap), 32'h1);

        out_ready = 1'b0;
        step();
        check("pre_rst_full", 32'(in_ready), 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_enc", 32'(enc_count), 32'h0);
        check("arst_err", 32'(err_count), 32'h0);
        check("arst_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_empty", 32'(out_valid), 32'h0);
        check("post_rst_inst", out_inst, 32'h0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
